// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared declarations for the bit-serial add controller:
//   - state_t       : controller state encoding (IDLE/RUN/DONE)
//   - DEFAULT_WIDTH : default operand/result width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell
//   One-bit full adder built from two halfAdder instances; the single
//   arithmetic resource that serial_adder_ctrl steps through each bit.
//   Ports: a, b - operand bits
//          ci   - carry in
//          s    - sum bit
//          co   - carry out (OR of the two half-adder carries)
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0;
  logic c0;
  logic c1;

  halfAdder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  halfAdder u_ha1 (
    .a     (s0),
    .b     (ci),
    .sum   (s),
    .carry (c1)
  );

  // Both half-adder carries can never be 1 together, so OR is exact.
  assign co = c0 | c1;

endmodule

// File: rtl/halfAdder.sv
// halfAdder
//   One-bit half adder.
//   Ports: a, b   - input bits
//          sum    - a XOR b
//          carry  - a AND b
module halfAdder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial WIDTH-bit adder controller. One full_adder_cell is reused
//   for WIDTH clock cycles, LSB first. Owns operand shift registers, the
//   carry flip-flop, the bit counter and the start/done handshake.
//
//   Ports:
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     start  - request, sampled only in IDLE
//     a, b   - operands, captured on the accepting edge
//     cin    - carry-in, captured on the accepting edge
//     busy   - high in RUN and DONE
//     done   - one-cycle pulse, result valid
//     sum    - registered result, held until the next completion
//     cout   - registered carry-out, held with sum
//     sub    - (only with SERIAL_ADDER_SUB_EN) 1 = compute a - b
//
//   Build option: define SERIAL_ADDER_SUB_EN to add the sub port. With
//   sub=1, b is inverted on capture and the carry FF is preset to 1
//   (cin ignored); cout=1 then means no borrow.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_SUB_EN
  ,
  input  logic             sub
`endif
);

  state_t state_reg;
  state_t state_next;

  logic [WIDTH-1:0] shift_a_reg;
  logic [WIDTH-1:0] shift_b_reg;
  logic [WIDTH-1:0] shift_s_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             cell_s;
  logic             cell_co;
  logic             last_bit;
  logic [WIDTH-1:0] sum_bits;

  // Operand B and initial carry as seen at capture time.
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = b;
  assign carry_load = cin;
`endif

  full_adder_cell u_cell (
    .a  (shift_a_reg[0]),
    .b  (shift_b_reg[0]),
    .ci (carry_reg),
    .s  (cell_s),
    .co (cell_co)
  );

  assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));
  // Result including the bit being produced this cycle.
  assign sum_bits = {cell_s, shift_s_reg[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, bit stepping and result load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a_reg <= '0;
      shift_b_reg <= '0;
      shift_s_reg <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            shift_a_reg <= a;
            shift_b_reg <= b_load;
            carry_reg   <= carry_load;
            cnt_reg     <= '0;
          end
        end
        RUN: begin
          shift_a_reg <= shift_a_reg >> 1;
          shift_b_reg <= shift_b_reg >> 1;
          shift_s_reg <= sum_bits;
          carry_reg   <= cell_co;
          if (last_bit) begin
            // Counter holds at WIDTH-1 on exit rather than wrapping.
            sum_reg  <= sum_bits;
            cout_reg <= cell_co;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
